// File: rtl/qint_vector_if.sv
// Bus bundle between the QSIC interrupt logic, its sources and the qint arbiter.
// master drives the device-side inputs; slave is the qint_vector block itself.
interface qint_vector_if #(
  parameter int NSRC = 4
);
  logic            RINIT;
  logic            RDIN;
  logic            assert_vector;
  logic            interrupt_request;
  logic [NSRC-1:0] int_event;
  logic [NSRC-1:0] int_enable;
  logic [6:0]      vector_base;
  logic [NSRC-1:0] int_pending;
  logic [NSRC-1:0] int_ack;
  logic [15:0]     TDAL;
  logic            tdal_oe;
  logic            TRPLY;

  modport master (
    output RINIT, RDIN, assert_vector, int_event, int_enable, vector_base,
    input  interrupt_request, int_pending, int_ack, TDAL, tdal_oe, TRPLY
  );

  modport slave (
    input  RINIT, RDIN, assert_vector, int_event, int_enable, vector_base,
    output interrupt_request, int_pending, int_ack, TDAL, tdal_oe, TRPLY
  );
endinterface

// File: rtl/qint_vector.sv
// Interrupt source manager and vector responder: collects source events, requests
// via qint, then drives the selected vector on DAL with the RPLY handshake.
module qint_vector #(
  parameter int NSRC      = 4,
  parameter int DAL_SETUP = 4,
  parameter int DAL_HOLD  = 2,
  parameter int REQ_GAP   = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  qint_vector_if.slave bus
);

  localparam int              SELW  = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int              CNT_W = 8;
  localparam logic [NSRC-1:0] ONE   = NSRC'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    VSETUP = 3'd2,
    VRPLY  = 3'd3,
    VHOLD  = 3'd4,
    GAP    = 3'd5
  } state_t;

  // Vector = base[8:2] plus 4*index, kept to 9 bits so any carry past 0777 is dropped.
  function automatic logic [15:0] vec_calc(input logic [6:0] base, input logic [SELW-1:0] idx);
    logic [8:0] off;
    logic [8:0] sum;
    off = 9'({idx, 2'b00});
    sum = {base, 2'b00} + off;
    return {7'b0000000, sum};
  endfunction

  logic rinit_m_r, rinit_s;
  logic rdin_m_r, rdin_s, rdin_d_r;
  logic av_m_r, av_s;

  state_t          state_r;
  logic [SELW-1:0] sel_r;
  logic [CNT_W-1:0] cnt_r;
  logic            req_r;
  logic [NSRC-1:0] pend_r;
  logic [NSRC-1:0] ack_r;
  logic [15:0]     tdal_r;
  logic            tdal_oe_r;
  logic            trply_r;

  logic            rdin_fall_s;
  logic            vrply_done_s;
  logic [NSRC-1:0] ready_s;
  logic [NSRC-1:0] pend_next_s;
  logic            cand_valid_s;
  logic [SELW-1:0] cand_idx_s;

  // Two-flop synchronizers for the asynchronous bus inputs, plus the RDIN edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rinit_m_r <= 1'b0;
      rinit_s   <= 1'b0;
      rdin_m_r  <= 1'b0;
      rdin_s    <= 1'b0;
      rdin_d_r  <= 1'b0;
      av_m_r    <= 1'b0;
      av_s      <= 1'b0;
    end else begin
      rinit_m_r <= bus.RINIT;
      rinit_s   <= rinit_m_r;
      rdin_m_r  <= bus.RDIN;
      rdin_s    <= rdin_m_r;
      rdin_d_r  <= rdin_s;
      av_m_r    <= bus.assert_vector;
      av_s      <= av_m_r;
    end
  end

  // Pending update and lowest-index candidate among enabled pending sources.
  always_comb begin
    rdin_fall_s  = rdin_d_r & ~rdin_s;
    vrply_done_s = (state_r == VRPLY) && !rdin_s;
    ready_s      = pend_r & bus.int_enable;
    if (vrply_done_s) begin
      pend_next_s = (pend_r & ~(ONE << sel_r)) | bus.int_event;
    end else begin
      pend_next_s = pend_r | bus.int_event;
    end
    cand_valid_s = 1'b0;
    cand_idx_s   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (ready_s[i]) begin
        cand_valid_s = 1'b1;
        cand_idx_s   = SELW'(i);
      end else begin
        cand_valid_s = cand_valid_s;
      end
    end
  end

  // Request / vector / reply sequencer with registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      sel_r     <= '0;
      cnt_r     <= '0;
      req_r     <= 1'b0;
      pend_r    <= '0;
      ack_r     <= '0;
      tdal_r    <= 16'h0000;
      tdal_oe_r <= 1'b0;
      trply_r   <= 1'b0;
    end else if (rinit_s) begin
      // Bus INIT clears everything and drops any event seen while it is held.
      state_r   <= IDLE;
      sel_r     <= '0;
      cnt_r     <= '0;
      req_r     <= 1'b0;
      pend_r    <= '0;
      ack_r     <= '0;
      tdal_r    <= 16'h0000;
      tdal_oe_r <= 1'b0;
      trply_r   <= 1'b0;
    end else begin
      ack_r  <= '0;
      pend_r <= pend_next_s;
      case (state_r)
        IDLE: begin
          if (cand_valid_s) begin
            sel_r   <= cand_idx_s;
            req_r   <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (av_s) begin
            tdal_r    <= vec_calc(bus.vector_base, sel_r);
            tdal_oe_r <= 1'b1;
            req_r     <= 1'b0;
            cnt_r     <= CNT_W'(DAL_SETUP);
            state_r   <= VSETUP;
          end
        end
        VSETUP: begin
          // An aborted IAK cycle releases DAL without replying; the source stays pending.
          if (rdin_fall_s) begin
            cnt_r   <= CNT_W'(DAL_HOLD);
            state_r <= VHOLD;
          end else if (cnt_r <= CNT_W'(1)) begin
            cnt_r   <= '0;
            trply_r <= 1'b1;
            state_r <= VRPLY;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        VRPLY: begin
          if (!rdin_s) begin
            trply_r <= 1'b0;
            ack_r   <= ONE << sel_r;
            cnt_r   <= CNT_W'(DAL_HOLD);
            state_r <= VHOLD;
          end
        end
        VHOLD: begin
          if (cnt_r <= CNT_W'(1)) begin
            tdal_oe_r <= 1'b0;
            tdal_r    <= 16'h0000;
            cnt_r     <= CNT_W'(REQ_GAP);
            state_r   <= GAP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r <= CNT_W'(1)) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          req_r     <= 1'b0;
          tdal_r    <= 16'h0000;
          tdal_oe_r <= 1'b0;
          trply_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interrupt_request = req_r;
  assign bus.int_pending       = pend_r;
  assign bus.int_ack           = ack_r;
  assign bus.TDAL              = tdal_r;
  assign bus.tdal_oe           = tdal_oe_r;
  assign bus.TRPLY             = trply_r;

endmodule
